// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution window sequencer.
package conv_pkg;

  // Frame-level sequencer state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } conv_state_e;

  // Number of output windows along one side (trailing rows/cols dropped).
  function automatic int calc_o(input int n, input int k, input int s);
    return (n - k) / s + 1;
  endfunction

  // Address width that never collapses to zero bits (e.g. O=1 or K=1).
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_aw(input int n);
    return clog2_min1(n * n);
  endfunction

  function automatic int calc_ww(input int k);
    return clog2_min1(k * k);
  endfunction

  function automatic int calc_ow(input int n, input int k, input int s);
    return clog2_min1(calc_o(n, k, s) * calc_o(n, k, s));
  endfunction

  // Legal configuration: kernel fits in the frame, stride and latency non-zero.
  function automatic bit cfg_ok(input int n, input int k, input int s, input int lat);
    return (k >= 1) && (k <= n) && (s >= 1) && (lat >= 1);
  endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Enable-gated shift register carrying {valid, output address} alongside the MAC latency.
module conv_tag_pipe #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic              v_q [DEPTH];
  logic [ADDR_W-1:0] a_q [DEPTH];

  // Shift one stage per enabled cycle; hold everything while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
      end
    end else if (en) begin
      v_q[0] <= in_valid;
      a_q[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        a_q[i] <= a_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_addr  = a_q[DEPTH-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every output window and kernel tap of one activation frame, issuing
// buffer addresses and MAC controls, and tags finished windows for downstream.
//
// Output handshake: a result is transferred in any cycle where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// whole datapath (tap counters, tap outputs, tag pipe) freezes via conv_en=0,
// so out_valid/out_addr stay stable until accepted.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int N       = 10,
  parameter int K       = 3,
  parameter int S       = 1,
  parameter int MAC_LAT = 2,
  localparam int O  = calc_o(N, K, S),
  localparam int AW = calc_aw(N),
  localparam int WW = calc_ww(K),
  localparam int OW = calc_ow(N, K, S)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          conv_en,
  output logic [AW-1:0] act_addr,
  output logic [WW-1:0] wgt_addr,
  output logic          mac_first,
  output logic          mac_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_addr
);

  if (!cfg_ok(N, K, S, MAC_LAT)) begin : g_cfg_check
    $error("conv_window_sequencer: need K<=N, S>=1, MAC_LAT>=1");
  end

  localparam int CW = clog2_min1(N + 1);

  conv_state_e   state;
  logic [CW-1:0] kc, kr, ocol, orow;
  logic          kc_last, kr_last, ocol_last, orow_last, frame_last;
  logic          stall, tap_adv, last_hs;
  logic [OW-1:0] win_addr;

  assign kc_last    = (kc == CW'(K - 1));
  assign kr_last    = (kr == CW'(K - 1));
  assign ocol_last  = (ocol == CW'(O - 1));
  assign orow_last  = (orow == CW'(O - 1));
  assign frame_last = kc_last && kr_last && ocol_last && orow_last;

  assign stall   = out_valid && !out_ready;
  assign conv_en = (state != IDLE) && !stall;
  assign tap_adv = (state == RUN) && conv_en;
  assign last_hs = out_valid && out_ready && (out_addr == OW'(O * O - 1));
  assign busy    = (state != IDLE);

  // Tap outputs are only meaningful while taps are being issued.
  assign act_addr  = (state == RUN)
                   ? AW'((32'(orow) * 32'(S) + 32'(kr)) * 32'(N) + 32'(ocol) * 32'(S) + 32'(kc))
                   : '0;
  assign wgt_addr  = (state == RUN) ? WW'(32'(kr) * 32'(K) + 32'(kc)) : '0;
  assign mac_first = (state == RUN) && (kc == '0) && (kr == '0);
  assign mac_last  = (state == RUN) && kc_last && kr_last;
  assign win_addr  = OW'(32'(orow) * 32'(O) + 32'(ocol));

  // Frame FSM and the registered done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (tap_adv && frame_last) state <= DRAIN;
        DRAIN:   if (last_hs) begin
                   state <= IDLE;
                   done  <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
    end
  end

  // Tap/window counters: kc fastest, then kr, ocol, orow; all wrap to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc   <= '0;
      kr   <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (tap_adv) begin
      kc <= kc_last ? '0 : kc + 1'b1;
      if (kc_last) begin
        kr <= kr_last ? '0 : kr + 1'b1;
        if (kr_last) begin
          ocol <= ocol_last ? '0 : ocol + 1'b1;
          if (ocol_last) begin
            orow <= orow_last ? '0 : orow + 1'b1;
          end
        end
      end
    end
  end

  conv_tag_pipe #(
    .DEPTH  (MAC_LAT),
    .ADDR_W (OW)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (conv_en),
    .in_valid  (mac_last),
    .in_addr   (mac_last ? win_addr : '0),
    .out_valid (out_valid),
    .out_addr  (out_addr)
  );

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: three configurations behind one output mux,
// checked cycle by cycle against an arithmetic model of tap and result timing.
module tb_conv_window_sequencer;
  import conv_pkg::*;

  localparam int N0 = 4, K0 = 3, S0 = 1, L0 = 2;
  localparam int N1 = 5, K1 = 3, S1 = 2, L1 = 3;
  localparam int N2 = 3, K2 = 3, S2 = 1, L2 = 1;
  localparam int CFG_N[3] = '{N0, N1, N2};
  localparam int CFG_K[3] = '{K0, K1, K2};
  localparam int CFG_S[3] = '{S0, S1, S2};
  localparam int CFG_L[3] = '{L0, L1, L2};

  localparam int AW0 = calc_aw(N0), WW0 = calc_ww(K0), OW0 = calc_ow(N0, K0, S0);
  localparam int AW1 = calc_aw(N1), WW1 = calc_ww(K1), OW1 = calc_ow(N1, K1, S1);
  localparam int AW2 = calc_aw(N2), WW2 = calc_ww(K2), OW2 = calc_ow(N2, K2, S2);

  logic clk, reset, start, out_ready;
  int   sel;
  int   n_cmp, n_err;

  logic busy0, done0, en0, first0, last0, ov0;
  logic busy1, done1, en1, first1, last1, ov1;
  logic busy2, done2, en2, first2, last2, ov2;
  logic [AW0-1:0] act0; logic [WW0-1:0] wgt0; logic [OW0-1:0] oa0;
  logic [AW1-1:0] act1; logic [WW1-1:0] wgt1; logic [OW1-1:0] oa1;
  logic [AW2-1:0] act2; logic [WW2-1:0] wgt2; logic [OW2-1:0] oa2;

  logic m_busy, m_done, m_en, m_first, m_last, m_ov;
  logic [7:0] m_act, m_wgt, m_oa;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_window_sequencer #(.N(N0), .K(K0), .S(S0), .MAC_LAT(L0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start && sel == 0), .busy(busy0), .done(done0),
    .conv_en(en0), .act_addr(act0), .wgt_addr(wgt0), .mac_first(first0), .mac_last(last0),
    .out_valid(ov0), .out_ready(out_ready), .out_addr(oa0));

  conv_window_sequencer #(.N(N1), .K(K1), .S(S1), .MAC_LAT(L1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start && sel == 1), .busy(busy1), .done(done1),
    .conv_en(en1), .act_addr(act1), .wgt_addr(wgt1), .mac_first(first1), .mac_last(last1),
    .out_valid(ov1), .out_ready(out_ready), .out_addr(oa1));

  conv_window_sequencer #(.N(N2), .K(K2), .S(S2), .MAC_LAT(L2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start && sel == 2), .busy(busy2), .done(done2),
    .conv_en(en2), .act_addr(act2), .wgt_addr(wgt2), .mac_first(first2), .mac_last(last2),
    .out_valid(ov2), .out_ready(out_ready), .out_addr(oa2));

  assign m_busy  = (sel == 0) ? busy0  : (sel == 1) ? busy1  : busy2;
  assign m_done  = (sel == 0) ? done0  : (sel == 1) ? done1  : done2;
  assign m_en    = (sel == 0) ? en0    : (sel == 1) ? en1    : en2;
  assign m_first = (sel == 0) ? first0 : (sel == 1) ? first1 : first2;
  assign m_last  = (sel == 0) ? last0  : (sel == 1) ? last1  : last2;
  assign m_ov    = (sel == 0) ? ov0    : (sel == 1) ? ov1    : ov2;
  assign m_act   = (sel == 0) ? 8'(act0) : (sel == 1) ? 8'(act1) : 8'(act2);
  assign m_wgt   = (sel == 0) ? 8'(wgt0) : (sel == 1) ? 8'(wgt1) : 8'(wgt2);
  assign m_oa    = (sel == 0) ? 8'(oa0)  : (sel == 1) ? 8'(oa1)  : 8'(oa2);

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d (cfg %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_conv_en"}, m_en, 0);
    chk({tag, "_act_addr"}, m_act, 0);
    chk({tag, "_wgt_addr"}, m_wgt, 0);
    chk({tag, "_mac_first"}, m_first, 0);
    chk({tag, "_mac_last"}, m_last, 0);
    chk({tag, "_out_valid"}, m_ov, 0);
    chk({tag, "_out_addr"}, m_oa, 0);
  endtask

  // Runs one frame on configuration c. Returns in the done cycle (or after an abort).
  //   stall_addr/stall_len : hold out_ready low for stall_len cycles when that result appears
  //   rand_ready           : otherwise drive out_ready randomly
  //   pulse_cyc            : cycle in which a stray start is pulsed while busy (-1 = none)
  //   abort_tap            : assert reset while this tap is presented (-1 = none)
  task automatic run_frame(input int c, input int stall_addr, input int stall_len,
                           input bit rand_ready, input int pulse_cyc, input int abort_tap);
    int n, k, s, lat, o, kk, t_total;
    int act, cyc, stall_left, p, j;
    bit exp_valid, rdy, hs_last, finished;
    logic [31:0] exp_act[$];
    logic [31:0] exp_wgt[$];
    n = CFG_N[c]; k = CFG_K[c]; s = CFG_S[c]; lat = CFG_L[c];
    o = (n - k) / s + 1;
    kk = k * k;
    t_total = o * o * kk;
    for (int orow = 0; orow < o; orow++)
      for (int ocol = 0; ocol < o; ocol++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            exp_act.push_back((orow * s + kr) * n + ocol * s + kc);
            exp_wgt.push_back(kr * k + kc);
          end
    sel = c;
    stall_left = stall_len;
    act = 0;
    hs_last = 1'b0;
    finished = 1'b0;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (!finished) begin
      #1;
      start = (cyc == pulse_cyc);
      if (hs_last) begin
        chk("done_pulse", m_done, 1);
        chk("busy_at_done", m_busy, 0);
        chk("conv_en_at_done", m_en, 0);
        chk("out_valid_at_done", m_ov, 0);
        finished = 1'b1;
      end else begin
        // Result j is presented once (j+1)*K*K + MAC_LAT - 1 enabled cycles have elapsed.
        p = act + 1 - lat;
        exp_valid = (p > 0) && (p % kk == 0) && (p / kk <= o * o);
        j = p / kk - 1;
        if (exp_valid && j == stall_addr && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else if (rand_ready) begin
          rdy = ($urandom_range(0, 3) != 0);
        end else begin
          rdy = 1'b1;
        end
        out_ready = rdy;
        #1;
        chk("busy", m_busy, 1);
        chk("done_idle", m_done, 0);
        chk("conv_en", m_en, !(exp_valid && !rdy));
        chk("out_valid", m_ov, exp_valid);
        if (exp_valid) chk("out_addr", m_oa, j);
        if (act < t_total) begin
          chk("mac_first", m_first, (act % kk) == 0);
          chk("mac_last", m_last, (act % kk) == kk - 1);
          chk("act_addr", m_act, exp_act[act]);
          chk("wgt_addr", m_wgt, exp_wgt[act]);
        end else begin
          chk("drain_mac_first", m_first, 0);
          chk("drain_mac_last", m_last, 0);
        end
        if (act == abort_tap) begin
          reset = 1'b1;
          #1;
          chk_all_zero("abort");
          repeat (2) @(posedge clk);
          #1;
          chk("abort_no_done", m_done, 0);
          chk("abort_idle", m_busy, 0);
          reset = 1'b0;
          finished = 1'b1;
        end else begin
          hs_last = exp_valid && rdy && (j == o * o - 1);
          if (!(exp_valid && !rdy)) act++;
        end
      end
      if (!finished) begin
        if (cyc > 4000) begin
          chk("frame_timeout", cyc, 0);
          finished = 1'b1;
        end else begin
          @(posedge clk);
          cyc++;
        end
      end
    end
  endtask

  // driver: directed steps followed by randomized frames
  initial begin
    n_cmp = 0;
    n_err = 0;
    sel = 0;
    start = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      sel = c;
      #1;
      chk_all_zero("reset");
    end
    sel = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", m_busy, 0);

    run_frame(0, -1, 0, 1'b0, -1, -1);   // N=4 K=3 S=1, free-running
    run_frame(0,  1, 5, 1'b0, -1, -1);   // 5-cycle backpressure on result 1
    run_frame(0, -1, 0, 1'b0, -1, 17);   // reset at tap 17
    run_frame(0, -1, 0, 1'b0, -1, -1);   // rerun from act_addr 0
    run_frame(0, -1, 0, 1'b0,  7, -1);   // stray start while busy
    run_frame(1, -1, 0, 1'b0, -1, -1);   // N=5 K=3 S=2
    run_frame(1,  2, 3, 1'b1,  4, -1);   // random ready plus directed stall
    run_frame(2, -1, 0, 1'b0, -1, -1);   // K==N single window
    run_frame(2,  0, 2, 1'b0, -1, -1);
    for (int r = 0; r < 6; r++) begin
      run_frame($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 6),
                1'b1, $urandom_range(2, 10), -1);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle_busy", m_busy, 0);
    chk("final_no_done", m_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
